pwm_ref_gen: RTL and testbench

Upstream tone sequencer for the audio PWM stage. It plays one note at a time by stepping a phase accumulator through a 32-entry sine table, once per PWM frame. It drives the 5-bit duty reference consumed by the PWM comparator. At note end it ramps the reference back to mid-scale so playback stops without a click.

---
 rtl/audio_pkg.sv | 22 ++
 rtl/sine_rom.sv | 11 +
 rtl/pwm_ref_gen.sv | 86 ++++++++
 tb/tb_pwm_ref_gen.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio definitions: sequencer state encoding, mid-scale level and the
// 32-entry sine table used by the tone sequencer and the PWM bench.
package audio_pkg;

  localparam int unsigned REF_W = 5;
  localparam logic [4:0]  MIDSCALE = 5'd16;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    RAMP
  } state_t;

  // round(16 + 15*sin(2*pi*i/32))
  localparam logic [4:0] SINE [32] = '{
    5'd16, 5'd19, 5'd22, 5'd24, 5'd27, 5'd28, 5'd30, 5'd31,
    5'd31, 5'd31, 5'd30, 5'd28, 5'd27, 5'd24, 5'd22, 5'd19,
    5'd16, 5'd13, 5'd10, 5'd8,  5'd5,  5'd4,  5'd2,  5'd1,
    5'd1,  5'd1,  5'd2,  5'd4,  5'd5,  5'd8,  5'd10, 5'd13
  };

endpackage

// File: rtl/sine_rom.sv
// Combinational 32x5 sine lookup.
module sine_rom
  import audio_pkg::*;
(
  input  logic [4:0] index,
  output logic [4:0] sine_val
);

  assign sine_val = SINE[index];

endmodule

// File: rtl/pwm_ref_gen.sv
// Tone sequencer: steps a phase accumulator through the sine table once per
// PWM frame, then ramps the duty reference back to mid-scale at note end.
module pwm_ref_gen
  import audio_pkg::*;
#(
  parameter int unsigned REF_W   = 5,
  parameter int unsigned PHASE_W = 16,
  parameter int unsigned DUR_W   = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               start,
  input  logic [PHASE_W-1:0] phase_inc,
  input  logic [DUR_W-1:0]   duration,
  output logic [REF_W-1:0]   pwm_ref,
  output logic               busy,
  output logic               done
);

  localparam logic [REF_W-1:0] MID = REF_W'(MIDSCALE);

  state_t             state;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] inc_q;
  logic [DUR_W-1:0]   remaining;
  logic [PHASE_W-1:0] phase_next;
  logic [4:0]         sine_val;

  assign phase_next = phase + inc_q;

  sine_rom u_sine_rom (
    .index    (phase_next[PHASE_W-1 -: 5]),
    .sine_val (sine_val)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      phase     <= '0;
      inc_q     <= '0;
      remaining <= '0;
      pwm_ref   <= MID;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          pwm_ref <= MID;
          if (start) begin
            inc_q     <= phase_inc;
            remaining <= duration;
            phase     <= '0;
            if (duration == '0) begin
              done <= 1'b1;
            end else begin
              state <= PLAY;
              busy  <= 1'b1;
            end
          end
        end
        PLAY: begin
          if (frame_tick) begin
            phase     <= phase_next;
            pwm_ref   <= REF_W'(sine_val);
            remaining <= remaining - 1'b1;
            if (remaining == DUR_W'(1)) state <= RAMP;
          end
        end
        RAMP: begin
          // Mid-scale check precedes stepping so a note ending on 16 exits at once.
          if (pwm_ref == MID) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (frame_tick) begin
            pwm_ref <= (pwm_ref < MID) ? pwm_ref + 1'b1 : pwm_ref - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_ref_gen.sv
// Self-checking bench for pwm_ref_gen using a scoreboard of expected duty values.
module tb_pwm_ref_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic        start;
  logic [15:0] phase_inc;
  logic [11:0] duration;
  logic [4:0]  pwm_ref;
  logic        busy;
  logic        done;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int          sine_m [32];
  logic [4:0]  exp_q [$];

  always #5 clk = ~clk;

  pwm_ref_gen #(.REF_W(5), .PHASE_W(16), .DUR_W(12)) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .start      (start),
    .phase_inc  (phase_inc),
    .duration   (duration),
    .pwm_ref    (pwm_ref),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp_v, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One frame tick; expected value queued on drive, compared one clk later.
  task automatic do_tick(input logic [4:0] exp_v);
    logic [4:0] e;
    frame_tick = 1'b1;
    exp_q.push_back(exp_v);
    step();
    frame_tick = 1'b0;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("pwm_ref", {27'd0, pwm_ref}, {27'd0, e});
    end
  endtask

  task automatic idle_cycle(input logic [4:0] cur);
    step();
    check("hold_ref", {27'd0, pwm_ref}, {27'd0, cur});
    check("busy_mid", {31'd0, busy}, 32'd1);
    check("done_mid", {31'd0, done}, 32'd0);
  endtask

  task automatic play_note(input logic [15:0] inc, input logic [11:0] dur, input bit ignored_start);
    logic [15:0] ph;
    logic [4:0]  cur;
    phase_inc  = inc;
    duration   = dur;
    start      = 1'b1;
    frame_tick = 1'b1;
    step();
    start      = 1'b0;
    frame_tick = 1'b0;
    phase_inc  = 16'hFFFF;
    duration   = 12'hFFF;
    if (dur == 12'd0) begin
      check("zero_done", {31'd0, done}, 32'd1);
      check("zero_busy", {31'd0, busy}, 32'd0);
      check("zero_ref", {27'd0, pwm_ref}, 32'd16);
      step();
      check("zero_done_clr", {31'd0, done}, 32'd0);
      check("zero_busy_clr", {31'd0, busy}, 32'd0);
      return;
    end
    check("busy_rise", {31'd0, busy}, 32'd1);
    check("start_done", {31'd0, done}, 32'd0);
    check("start_ref", {27'd0, pwm_ref}, 32'd16);
    ph  = 16'd0;
    cur = 5'd16;
    for (int unsigned k = 1; k <= dur; k++) begin
      if (ignored_start && k == 3) begin
        start     = 1'b1;
        phase_inc = 16'h1234;
        duration  = 12'd5;
      end
      idle_cycle(cur);
      start = 1'b0;
      ph  = ph + inc;
      cur = 5'(sine_m[ph[15:11]]);
      do_tick(cur);
    end
    while (cur != 5'd16) begin
      idle_cycle(cur);
      cur = (cur < 5'd16) ? cur + 5'd1 : cur - 5'd1;
      do_tick(cur);
    end
    step();
    check("end_done", {31'd0, done}, 32'd1);
    check("end_busy", {31'd0, busy}, 32'd0);
    check("end_ref", {27'd0, pwm_ref}, 32'd16);
    step();
    check("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic [15:0] ph;
    for (int i = 0; i < 32; i++)
      sine_m[i] = $rtoi(16.0 + 15.0 * $sin(2.0 * 3.14159265358979 * i / 32.0) + 0.5);

    reset      = 1'b1;
    frame_tick = 1'b0;
    start      = 1'b0;
    phase_inc  = '0;
    duration   = '0;
    repeat (3) step();
    reset = 1'b0;
    check("rst_ref", {27'd0, pwm_ref}, 32'd16);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    for (int i = 0; i < 10; i++) do_tick(5'd16);
    check("idle_busy", {31'd0, busy}, 32'd0);

    play_note(16'd2048, 12'd32, 1'b0);
    play_note(16'd16384, 12'd1, 1'b0);
    play_note(16'd777, 12'd0, 1'b0);
    play_note(16'd2048, 12'd32, 1'b1);
    play_note(16'd0, 12'd5, 1'b0);
    play_note(16'd5000, 12'd9, 1'b0);

    // Reset in the middle of a note.
    phase_inc = 16'd2048;
    duration  = 12'd32;
    start     = 1'b1;
    step();
    start = 1'b0;
    ph = 16'd0;
    for (int i = 0; i < 5; i++) begin
      ph = ph + 16'd2048;
      do_tick(5'(sine_m[ph[15:11]]));
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_ref", {27'd0, pwm_ref}, 32'd16);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    for (int i = 0; i < 40; i++) begin
      frame_tick = i[0];
      step();
      check("midrst_no_done", {31'd0, done}, 32'd0);
      check("midrst_idle_ref", {27'd0, pwm_ref}, 32'd16);
    end
    frame_tick = 1'b0;
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
